// File: rtl/nco_sweep.sv
// Numerically controlled oscillator phase generator with fixed-frequency and
// linear up-sweep modes; the accumulator is never touched by command loads.
module nco_sweep #(
  parameter int ACC_WIDTH   = 24,
  parameter int PHASE_WIDTH = 13
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic                   i_mode,
  input  logic [ACC_WIDTH-1:0]   i_fcw,
  input  logic [ACC_WIDTH-1:0]   i_fcw_stop,
  input  logic [ACC_WIDTH-1:0]   i_fstep,
  input  logic                   i_phase_clr,
  output logic [PHASE_WIDTH-1:0] o_phase,
  output logic                   o_valid,
  output logic                   o_busy,
  output logic                   o_sweep_done
);

  typedef enum logic [1:0] {IDLE, RUN, SWEEP} state_t;

  state_t                 state_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [ACC_WIDTH-1:0]   fcw_q;
  logic [ACC_WIDTH-1:0]   stop_q;
  logic [ACC_WIDTH-1:0]   step_q;
  logic [PHASE_WIDTH-1:0] phase_q;
  logic                   valid_q;
  logic                   done_q;

  logic                   cmd_accept;
  logic [ACC_WIDTH:0]     sweep_sum;
  logic [ACC_WIDTH-1:0]   acc_d;

  assign cmd_accept = i_cmd_valid && (state_q != SWEEP);
  // One extra bit so a step that overflows the word still counts as reaching stop.
  assign sweep_sum  = {1'b0, fcw_q} + {1'b0, step_q};

  always_comb begin
    acc_d = acc_q;
    if (i_phase_clr)
      acc_d = '0;
    else if (i_en && (state_q != IDLE))
      acc_d = acc_q + fcw_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      fcw_q   <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      phase_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      valid_q <= i_en;
      done_q  <= 1'b0;
      if (i_en)
        phase_q <= acc_d[ACC_WIDTH-1 -: PHASE_WIDTH];

      case (state_q)
        IDLE, RUN: begin
          if (cmd_accept) begin
            if (!i_mode) begin
              fcw_q   <= i_fcw;
              state_q <= RUN;
            end else begin
              stop_q <= i_fcw_stop;
              step_q <= i_fstep;
              // A sweep that cannot make progress finishes immediately at its end word.
              if ((i_fstep == '0) || (i_fcw >= i_fcw_stop)) begin
                fcw_q   <= i_fcw_stop;
                state_q <= RUN;
                done_q  <= 1'b1;
              end else begin
                fcw_q   <= i_fcw;
                state_q <= SWEEP;
              end
            end
          end
        end
        SWEEP: begin
          if (i_en) begin
            if (sweep_sum >= {1'b0, stop_q}) begin
              fcw_q   <= stop_q;
              state_q <= RUN;
              done_q  <= 1'b1;
            end else begin
              fcw_q <= sweep_sum[ACC_WIDTH-1:0];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_cmd_ready  = (state_q != SWEEP);
  assign o_busy       = (state_q == SWEEP);
  assign o_phase      = phase_q;
  assign o_valid      = valid_q;
  assign o_sweep_done = done_q;

endmodule

// File: tb/tb_nco_sweep.sv
// Directed bench for nco_sweep: fixed wrap, sweep, degenerate sweep, busy
// rejection, phase clear, same-cycle retune and reset mid-sweep.
module tb_nco_sweep;

  logic        clk = 1'b0;
  logic        rst, en, cmd_valid, mode, phase_clr;
  logic [23:0] fcw, fcw_stop, fstep;
  logic        cmd_ready, valid, busy, sweep_done;
  logic [12:0] phase;

  int n_cmp = 0;
  int n_err = 0;

  nco_sweep #(.ACC_WIDTH(24), .PHASE_WIDTH(13)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready), .i_mode(mode), .i_fcw(fcw),
    .i_fcw_stop(fcw_stop), .i_fstep(fstep), .i_phase_clr(phase_clr),
    .o_phase(phase), .o_valid(valid), .o_busy(busy), .o_sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 0; cmd_valid = 0; mode = 0; phase_clr = 0;
    fcw = '0; fcw_stop = '0; fstep = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; en = 1; cmd_valid = 1; fcw = 24'h123456;
    tick(); tick();
    n_cmp++; if (phase !== 13'h0) begin n_err++; $display("FAIL reset_phase got=%h exp=0", phase); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (sweep_done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", sweep_done); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    rst = 0; idle_inputs();
    $display("test_reset done");
  endtask

  task automatic test_fixed_wrap();
    logic [12:0] exp_ph;
    do_reset();
    cmd_valid = 1; mode = 0; fcw = 24'h080000;
    tick();
    cmd_valid = 0; en = 1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      exp_ph = 13'(k * 32'h100);
      n_cmp++; if (phase !== exp_ph) begin n_err++; $display("FAIL wrap_phase[%0d] got=%h exp=%h", k, phase, exp_ph); end
      n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL wrap_valid[%0d] got=%b exp=1", k, valid); end
    end
    en = 0;
    $display("test_fixed_wrap done");
  endtask

  task automatic test_sweep();
    logic [23:0] exp_fcw [4] = '{24'h100, 24'h200, 24'h300, 24'h400};
    logic [23:0] exp_acc [4] = '{24'h000, 24'h100, 24'h300, 24'h600};
    logic        exp_busy[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        exp_done[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    cmd_valid = 1; mode = 1; fcw = 24'h100; fcw_stop = 24'h400; fstep = 24'h100;
    for (int k = 0; k < 4; k++) begin
      tick();
      cmd_valid = 0; en = 1;
      n_cmp++; if (dut.fcw_q !== exp_fcw[k]) begin n_err++; $display("FAIL sweep_fcw[%0d] got=%h exp=%h", k, dut.fcw_q, exp_fcw[k]); end
      n_cmp++; if (dut.acc_q !== exp_acc[k]) begin n_err++; $display("FAIL sweep_acc[%0d] got=%h exp=%h", k, dut.acc_q, exp_acc[k]); end
      n_cmp++; if (busy !== exp_busy[k]) begin n_err++; $display("FAIL sweep_busy[%0d] got=%b exp=%b", k, busy, exp_busy[k]); end
      n_cmp++; if (cmd_ready !== !exp_busy[k]) begin n_err++; $display("FAIL sweep_ready[%0d] got=%b exp=%b", k, cmd_ready, !exp_busy[k]); end
      n_cmp++; if (sweep_done !== exp_done[k]) begin n_err++; $display("FAIL sweep_done[%0d] got=%b exp=%b", k, sweep_done, exp_done[k]); end
    end
    tick();
    n_cmp++; if (sweep_done !== 1'b0) begin n_err++; $display("FAIL sweep_done_once got=%b exp=0", sweep_done); end
    n_cmp++; if (dut.acc_q !== 24'hA00) begin n_err++; $display("FAIL sweep_run_acc got=%h exp=a00", dut.acc_q); end
    en = 0;
    $display("test_sweep done");
  endtask

  task automatic test_degenerate();
    do_reset();
    cmd_valid = 1; mode = 1; fcw = 24'h123; fcw_stop = 24'h456; fstep = 24'h0;
    tick();
    cmd_valid = 0;
    n_cmp++; if (dut.fcw_q !== 24'h456) begin n_err++; $display("FAIL degen_fcw got=%h exp=456", dut.fcw_q); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL degen_busy got=%b exp=0", busy); end
    n_cmp++; if (sweep_done !== 1'b1) begin n_err++; $display("FAIL degen_done got=%b exp=1", sweep_done); end
    tick();
    n_cmp++; if (sweep_done !== 1'b0) begin n_err++; $display("FAIL degen_done_once got=%b exp=0", sweep_done); end
    cmd_valid = 1; mode = 1; fcw = 24'h500; fcw_stop = 24'h400; fstep = 24'h1;
    tick();
    cmd_valid = 0;
    n_cmp++; if (dut.fcw_q !== 24'h400) begin n_err++; $display("FAIL degen2_fcw got=%h exp=400", dut.fcw_q); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL degen2_busy got=%b exp=0", busy); end
    n_cmp++; if (sweep_done !== 1'b1) begin n_err++; $display("FAIL degen2_done got=%b exp=1", sweep_done); end
    $display("test_degenerate done");
  endtask

  task automatic test_busy_ignore();
    logic [23:0] exp_fcw [3] = '{24'h200, 24'h300, 24'h400};
    do_reset();
    cmd_valid = 1; mode = 1; fcw = 24'h100; fcw_stop = 24'h400; fstep = 24'h100;
    tick();
    mode = 0; fcw = 24'hABCDE; en = 1;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) cmd_valid = 0;
      tick();
      n_cmp++; if (dut.fcw_q !== exp_fcw[k]) begin n_err++; $display("FAIL ignore_fcw[%0d] got=%h exp=%h", k, dut.fcw_q, exp_fcw[k]); end
    end
    n_cmp++; if (dut.acc_q !== 24'h600) begin n_err++; $display("FAIL ignore_acc got=%h exp=600", dut.acc_q); end
    en = 0;
    $display("test_busy_ignore done");
  endtask

  task automatic test_phase_clr();
    do_reset();
    cmd_valid = 1; mode = 0; fcw = 24'h080000;
    tick();
    cmd_valid = 0; en = 1;
    tick(); tick(); tick();
    n_cmp++; if (phase !== 13'h300) begin n_err++; $display("FAIL clr_pre got=%h exp=300", phase); end
    phase_clr = 1;
    tick();
    phase_clr = 0;
    n_cmp++; if (phase !== 13'h0) begin n_err++; $display("FAIL clr_phase got=%h exp=0", phase); end
    n_cmp++; if (valid !== 1'b1) begin n_err++; $display("FAIL clr_valid got=%b exp=1", valid); end
    tick();
    n_cmp++; if (phase !== 13'h100) begin n_err++; $display("FAIL clr_next got=%h exp=100", phase); end
    en = 0;
    $display("test_phase_clr done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    cmd_valid = 1; mode = 0; fcw = 24'h080000;
    tick();
    cmd_valid = 0; en = 1;
    tick(); tick();
    cmd_valid = 1; fcw = 24'h100000;
    tick();
    cmd_valid = 0;
    n_cmp++; if (phase !== 13'h300) begin n_err++; $display("FAIL b2b_old_fcw got=%h exp=300", phase); end
    tick();
    n_cmp++; if (phase !== 13'h500) begin n_err++; $display("FAIL b2b_new_fcw got=%h exp=500", phase); end
    en = 0;
    tick();
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid_low got=%b exp=0", valid); end
    n_cmp++; if (phase !== 13'h500) begin n_err++; $display("FAIL b2b_hold got=%h exp=500", phase); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid_sweep();
    do_reset();
    cmd_valid = 1; mode = 1; fcw = 24'h100; fcw_stop = 24'h400; fstep = 24'h100;
    tick();
    cmd_valid = 0; en = 1;
    tick();
    rst = 1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got=%b exp=1", cmd_ready); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got=%b exp=0", valid); end
    n_cmp++; if (phase !== 13'h0) begin n_err++; $display("FAIL rstmid_phase got=%h exp=0", phase); end
    n_cmp++; if (sweep_done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got=%b exp=0", sweep_done); end
    n_cmp++; if (dut.fcw_q !== 24'h0) begin n_err++; $display("FAIL rstmid_fcw got=%h exp=0", dut.fcw_q); end
    rst = 0; en = 0; cmd_valid = 1; mode = 0; fcw = 24'h080000;
    tick();
    cmd_valid = 0; en = 1;
    n_cmp++; if (sweep_done !== 1'b0) begin n_err++; $display("FAIL rstmid_nodone got=%b exp=0", sweep_done); end
    n_cmp++; if (dut.fcw_q !== 24'h080000) begin n_err++; $display("FAIL rstmid_newcmd got=%h exp=080000", dut.fcw_q); end
    tick();
    n_cmp++; if (phase !== 13'h100) begin n_err++; $display("FAIL rstmid_phase1 got=%h exp=100", phase); end
    en = 0;
    $display("test_reset_mid_sweep done");
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_fixed_wrap();
    test_sweep();
    test_degenerate();
    test_busy_ignore();
    test_phase_clr();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
